// File: rtl/countdown_clock_if.sv
// Control, load and status signals of the hh:mm:ss countdown timer.
// The master drives ticks, commands and limits; the slave (the timer) drives the counts and pulses.
interface countdown_clock_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             load;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] load_sec;
    logic [WIDTH-1:0] load_min;
    logic [WIDTH-1:0] load_hrs;
    logic [WIDTH-1:0] count_max;
    logic [WIDTH-1:0] count_max_hrs;
    logic [WIDTH-1:0] count_sec;
    logic [WIDTH-1:0] count_min;
    logic [WIDTH-1:0] count_hrs;
    logic             borrow_sec;
    logic             borrow_min;
    logic             running;
    logic             done;

    modport master (
        output en, load, start, stop,
        output load_sec, load_min, load_hrs, count_max, count_max_hrs,
        input  count_sec, count_min, count_hrs,
        input  borrow_sec, borrow_min, running, done
    );

    modport slave (
        input  en, load, start, stop,
        input  load_sec, load_min, load_hrs, count_max, count_max_hrs,
        output count_sec, count_min, count_hrs,
        output borrow_sec, borrow_min, running, done
    );
endinterface

// File: rtl/countdown_clock.sv
// Down-counting hh:mm:ss timer with borrow cascade sec -> min -> hrs.
// It pulses done when the count reaches 00:00:00 and never wraps below zero.
module countdown_clock #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    countdown_clock_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sec_q;
    logic [WIDTH-1:0] min_q;
    logic [WIDTH-1:0] hrs_q;
    logic             borrow_sec_q;
    logic             borrow_min_q;
    logic             running_q;
    logic             done_q;

    logic [WIDTH-1:0] dec_sec;
    logic [WIDTH-1:0] dec_min;
    logic [WIDTH-1:0] dec_hrs;
    logic             dec_borrow_sec;
    logic             dec_borrow_min;
    logic             dec_zero;
    logic             counts_zero;
    logic [WIDTH-1:0] clamp_sec;
    logic [WIDTH-1:0] clamp_min;
    logic [WIDTH-1:0] clamp_hrs;

    // One-second step; a zero field is only ever reloaded, never decremented.
    always_comb begin
        dec_sec        = sec_q;
        dec_min        = min_q;
        dec_hrs        = hrs_q;
        dec_borrow_sec = 1'b0;
        dec_borrow_min = 1'b0;
        if (sec_q != '0) begin
            dec_sec = sec_q - WIDTH'(1);
        end else if (min_q != '0) begin
            dec_sec        = bus.count_max;
            dec_min        = min_q - WIDTH'(1);
            dec_borrow_sec = 1'b1;
        end else if (hrs_q != '0) begin
            dec_sec        = bus.count_max;
            dec_min        = bus.count_max;
            dec_hrs        = hrs_q - WIDTH'(1);
            dec_borrow_sec = 1'b1;
            dec_borrow_min = 1'b1;
        end
    end

    assign dec_zero    = (dec_sec == '0) && (dec_min == '0) && (dec_hrs == '0);
    assign counts_zero = (sec_q == '0) && (min_q == '0) && (hrs_q == '0);

    assign clamp_sec = (bus.load_sec > bus.count_max)     ? bus.count_max     : bus.load_sec;
    assign clamp_min = (bus.load_min > bus.count_max)     ? bus.count_max     : bus.load_min;
    assign clamp_hrs = (bus.load_hrs > bus.count_max_hrs) ? bus.count_max_hrs : bus.load_hrs;

    // Command priority is load > stop > start > en; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sec_q        <= '0;
            min_q        <= '0;
            hrs_q        <= '0;
            borrow_sec_q <= 1'b0;
            borrow_min_q <= 1'b0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            borrow_sec_q <= 1'b0;
            borrow_min_q <= 1'b0;
            done_q       <= 1'b0;
            if (bus.load) begin
                sec_q     <= clamp_sec;
                min_q     <= clamp_min;
                hrs_q     <= clamp_hrs;
                state     <= IDLE;
                running_q <= 1'b0;
            end else if (bus.stop && state == RUN) begin
                state     <= PAUSE;
                running_q <= 1'b0;
            end else if (bus.start && state != RUN) begin
                if (counts_zero) begin
                    done_q    <= 1'b1;
                    state     <= IDLE;
                    running_q <= 1'b0;
                end else begin
                    state     <= RUN;
                    running_q <= 1'b1;
                end
            end else if (bus.en && state == RUN) begin
                sec_q        <= dec_sec;
                min_q        <= dec_min;
                hrs_q        <= dec_hrs;
                borrow_sec_q <= dec_borrow_sec;
                borrow_min_q <= dec_borrow_min;
                // The tick that lands on 00:00:00 finishes the countdown immediately.
                if (dec_zero) begin
                    done_q    <= 1'b1;
                    state     <= IDLE;
                    running_q <= 1'b0;
                end
            end
        end
    end

    assign bus.count_sec  = sec_q;
    assign bus.count_min  = min_q;
    assign bus.count_hrs  = hrs_q;
    assign bus.borrow_sec = borrow_sec_q;
    assign bus.borrow_min = borrow_min_q;
    assign bus.running    = running_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_countdown_clock.sv
// Scoreboard bench for countdown_clock: directed scenarios plus random commands,
// checked against a model that counts down in total seconds and splits back into fields.
module tb_countdown_clock;
    localparam int W = 32;

    typedef struct {
        longint unsigned sec;
        longint unsigned min;
        longint unsigned hrs;
        bit              borrow_sec;
        bit              borrow_min;
        bit              running;
        bit              done;
    } exp_t;

    logic clk;
    logic reset;
    countdown_clock_if #(.WIDTH(W)) bus ();

    countdown_clock #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   assert_count = 0;
    int   fail_count   = 0;

    longint unsigned cfg_sec, cfg_min, cfg_hrs, cfg_cm, cfg_cmh;
    longint unsigned m_sec, m_min, m_hrs;
    bit              m_running, m_done, m_bs, m_bm;

    // Reference: the time is one number of seconds in base (count_max+1).
    task automatic modelStep(input bit rst, ld, st, sp, e);
        longint unsigned b, total;
        m_done = 0;
        m_bs   = 0;
        m_bm   = 0;
        b      = cfg_cm + 1;
        total  = m_hrs * b * b + m_min * b + m_sec;
        if (rst) begin
            m_sec = 0; m_min = 0; m_hrs = 0; m_running = 0;
        end else if (ld) begin
            m_sec     = (cfg_sec > cfg_cm)  ? cfg_cm  : cfg_sec;
            m_min     = (cfg_min > cfg_cm)  ? cfg_cm  : cfg_min;
            m_hrs     = (cfg_hrs > cfg_cmh) ? cfg_cmh : cfg_hrs;
            m_running = 0;
        end else if (sp && m_running) begin
            m_running = 0;
        end else if (st && !m_running) begin
            if (total == 0) m_done = 1;
            else            m_running = 1;
        end else if (e && m_running) begin
            m_bs  = (m_sec == 0);
            m_bm  = (m_sec == 0) && (m_min == 0);
            total = total - 1;
            m_sec = total % b;
            m_min = (total / b) % b;
            m_hrs = total / (b * b);
            if (total == 0) begin
                m_done    = 1;
                m_running = 0;
            end
        end
    endtask

    task automatic applyStimulus(input bit rst, ld, st, sp, e);
        exp_t x;
        @(negedge clk);
        reset             = rst;
        bus.load          = ld;
        bus.start         = st;
        bus.stop          = sp;
        bus.en            = e;
        bus.load_sec      = W'(cfg_sec);
        bus.load_min      = W'(cfg_min);
        bus.load_hrs      = W'(cfg_hrs);
        bus.count_max     = W'(cfg_cm);
        bus.count_max_hrs = W'(cfg_cmh);
        modelStep(rst, ld, st, sp, e);
        x.sec = m_sec; x.min = m_min; x.hrs = m_hrs;
        x.borrow_sec = m_bs; x.borrow_min = m_bm;
        x.running = m_running; x.done = m_done;
        exp_q.push_back(x);
    endtask

    task automatic checkField(input string name, input longint unsigned act, input longint unsigned exp);
        assert_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t x);
        checkField("count_sec",  64'(bus.count_sec),  x.sec);
        checkField("count_min",  64'(bus.count_min),  x.min);
        checkField("count_hrs",  64'(bus.count_hrs),  x.hrs);
        checkField("borrow_sec", 64'(bus.borrow_sec), 64'(x.borrow_sec));
        checkField("borrow_min", 64'(bus.borrow_min), 64'(x.borrow_min));
        checkField("running",    64'(bus.running),    64'(x.running));
        checkField("done",       64'(bus.done),       64'(x.done));
    endtask

    // Monitor: every edge produces one registered result to compare.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    task automatic loadTime(input longint unsigned h, m, s);
        cfg_hrs = h; cfg_min = m; cfg_sec = s;
        applyStimulus(0, 1, 0, 0, 0);
    endtask

    initial begin
        int r;
        reset = 1'b1;
        bus.load = 0; bus.start = 0; bus.stop = 0; bus.en = 0;
        bus.load_sec = '0; bus.load_min = '0; bus.load_hrs = '0;
        bus.count_max = W'(59); bus.count_max_hrs = W'(23);
        cfg_sec = 0; cfg_min = 0; cfg_hrs = 0; cfg_cm = 59; cfg_cmh = 23;
        m_sec = 0; m_min = 0; m_hrs = 0; m_running = 0;
        m_done = 0; m_bs = 0; m_bm = 0;

        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        loadTime(0, 1, 0);                   // minute borrow
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);

        loadTime(1, 0, 0);                   // hour borrow
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);

        loadTime(0, 0, 2);                   // terminal tick, then hold at zero
        applyStimulus(0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);

        loadTime(0, 0, 10);                  // pause and resume
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 1);

        loadTime(30, 80, 75);                // clamp to limits
        loadTime(0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        loadTime(0, 0, 5);                   // reset dominates everything
        applyStimulus(0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);

        cfg_cm = 5;                          // raised limit reaches only the next reload
        loadTime(0, 1, 0);
        applyStimulus(0, 0, 1, 0, 0);
        cfg_cm = 9;
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 1) begin
                applyStimulus(1, 0, 0, 0, $urandom_range(0, 1) == 1);
            end else if (r < 6) begin
                cfg_cm  = $urandom_range(1, 9);
                cfg_cmh = $urandom_range(0, 3);
                cfg_sec = $urandom_range(0, 12);
                cfg_min = $urandom_range(0, 12);
                cfg_hrs = $urandom_range(0, 5);
                applyStimulus(0, 1, $urandom_range(0, 1) == 1, 0, $urandom_range(0, 1) == 1);
            end else if (r < 12) begin
                applyStimulus(0, 0, 0, 1, $urandom_range(0, 1) == 1);
            end else if (r < 24) begin
                applyStimulus(0, 0, 1, 0, $urandom_range(0, 1) == 1);
            end else begin
                applyStimulus(0, 0, 0, 0, $urandom_range(0, 3) != 0);
            end
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            fail_count++;
            $display("[TB] FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
